// File: rtl/g3f_pkg.sv
// Shared constants for the g3f multiphase sequencer.
//   MODE_JOHNSON / MODE_RING : values of the mode input
//   DIR_UP / DIR_DOWN        : values of the dir input
package g3f_pkg;
  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
endpackage

// File: rtl/phase_prescaler.sv
// Prescaler for the multiphase sequencer: asserts tick once every div+1
// enabled cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable; low clears the count
//   div        : divide value, may change at any time
//   tick       : combinational advance request for the current cycle
module phase_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt;

  // Compare with >= so that lowering div below the current count ticks at once.
  assign tick = en && (cnt >= div);

  // Cycle counter, cleared while disabled and on every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/multiphase_phase_gen.sv
// Multiphase sequencer: Johnson (2*STAGES phases) or one-hot ring (STAGES
// phases) shift register with prescaled advance, direction control, phase
// decode and self-repair of illegal states.
//   clk, rst_n : clock, asynchronous active-low reset
//   en, dir    : run enable, direction (0 up, 1 down)
//   mode       : 0 Johnson, 1 ring
//   div        : advance once every div+1 cycles
//   q          : registered shift-register state
//   phase      : phase index decoded from q
//   phase_oh   : one-hot of phase
//   wrap       : registered pulse when an advance lands on phase 0
//   fix        : registered pulse when an illegal state is repaired
module multiphase_phase_gen
  import g3f_pkg::*;
#(
  parameter  int STAGES = 3,
  parameter  int DIV_W  = 8,
  localparam int PH_W   = $clog2(2 * STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  mode,
  input  logic [DIV_W-1:0]      div,
  output logic [STAGES-1:0]     q,
  output logic [PH_W-1:0]       phase,
  output logic [2*STAGES-1:0]   phase_oh,
  output logic                  wrap,
  output logic                  fix
);

  localparam logic [STAGES-1:0]   Q_ONE  = {{(STAGES-1){1'b0}}, 1'b1};
  localparam logic [2*STAGES-1:0] OH_ONE = {{(2*STAGES-1){1'b0}}, 1'b1};
  localparam logic [PH_W-1:0]     PH_ONE = {{(PH_W-1){1'b0}}, 1'b1};
  // 2N reduced modulo 2^PH_W; 2N-pc stays correct because pc >= 1 there.
  localparam logic [PH_W-1:0]     TWO_N  = PH_W'(2 * STAGES);

  logic              tick;
  logic              legal;
  logic [STAGES-1:0] q_adv;
  logic [STAGES-1:0] q_next;
  logic              wrap_next;
  logic              fix_next;

  // Legal Johnson codes are a run of ones anchored at either end of q.
  function automatic logic johnson_legal(input logic [STAGES-1:0] v);
    logic [STAGES-1:0] inv;
    inv = ~v;
    return (((v & (v + Q_ONE)) == '0) || ((inv & (inv + Q_ONE)) == '0));
  endfunction

  function automatic logic ring_legal(input logic [STAGES-1:0] v);
    return ((v != '0) && ((v & (v - Q_ONE)) == '0));
  endfunction

  function automatic logic [PH_W-1:0] decode(input logic [STAGES-1:0] v,
                                             input logic              m);
    logic [PH_W-1:0] idx;
    logic [PH_W-1:0] pc;
    idx = '0;
    pc  = '0;
    if (m == MODE_RING) begin
      for (int i = 0; i < STAGES; i++) begin
        if (v[i]) begin
          idx = i[PH_W-1:0];
        end else begin
          idx = idx;
        end
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        pc = pc + (v[i] ? PH_ONE : '0);
      end
      if (pc == '0) begin
        idx = '0;
      end else if (v[0]) begin
        idx = pc;
      end else begin
        idx = TWO_N - pc;
      end
    end
    return idx;
  endfunction

  phase_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
    .tick  (tick)
  );

  assign legal    = (mode == MODE_RING) ? ring_legal(q) : johnson_legal(q);
  assign phase    = decode(q, mode);
  assign phase_oh = OH_ONE << phase;

  // Candidate next state for one advance in the selected mode/direction.
  always_comb begin
    q_adv = q;
    case ({mode, dir})
      {MODE_JOHNSON, DIR_UP}:   q_adv = {q[STAGES-2:0], ~q[STAGES-1]};
      {MODE_JOHNSON, DIR_DOWN}: q_adv = {~q[0], q[STAGES-1:1]};
      {MODE_RING, DIR_UP}:      q_adv = {q[STAGES-2:0], q[STAGES-1]};
      {MODE_RING, DIR_DOWN}:    q_adv = {q[0], q[STAGES-1:1]};
      default:                  q_adv = q;
    endcase
  end

  // Repair beats advance; wrap only flags an advance landing on phase 0.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    fix_next  = 1'b0;
    if (!legal) begin
      q_next   = (mode == MODE_RING) ? Q_ONE : '0;
      fix_next = 1'b1;
    end else if (tick) begin
      q_next    = q_adv;
      wrap_next = (decode(q_adv, mode) == '0);
    end else begin
      q_next = q;
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
      fix  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
      fix  <= fix_next;
    end
  end

endmodule
